// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the core and the iterative multiply/divide engine.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] mul_h;
    logic [WIDTH-1:0] mul_l;

    // Core side: issues the operation and watches for completion.
    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, mul_h, mul_l
    );

    // Engine side.
    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, mul_h, mul_l
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine: one bit per cycle over 32 RUN cycles,
// then a FIX cycle applies sign correction and writes the HI/LO pair.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    mul_div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      cnt_reg;
    logic [1:0]         op_reg;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic               sa_reg, sb_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               done_reg, dz_reg;

    // Operand conditioning at accept: magnitudes for signed ops, raw for unsigned.
    logic               in_signed, in_sa, in_sb;
    logic [WIDTH-1:0]   in_a, in_b;

    // Per-cycle iteration results.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     rem_shift;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] div_step;

    // Completion values.
    logic               is_div, is_signed, neg_res, div0;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, hi_fix, lo_fix;

    // Operand magnitude/sign extraction from the live inputs.
    always_comb begin
        in_signed = ~bus.op[0];
        in_sa     = in_signed & bus.a[WIDTH-1];
        in_sb     = in_signed & bus.b[WIDTH-1];
        in_a      = in_sa ? -bus.a : bus.a;
        in_b      = in_sb ? -bus.b : bus.b;
    end

    // One shift-add multiply step (LSB first) and one restoring divide step (MSB first).
    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                  + (b_reg[cnt_reg] ? {1'b0, a_reg} : '0);
        mul_step  = {mul_sum, acc_reg[WIDTH-1:1]};
        rem_shift = {acc_reg[2*WIDTH-1:WIDTH], a_reg[CW'(WIDTH-1) - cnt_reg]};
        q_bit     = (rem_shift >= {1'b0, b_reg});
        rem_new   = WIDTH'(q_bit ? (rem_shift - {1'b0, b_reg}) : rem_shift);
        div_step  = {rem_new, acc_reg[WIDTH-2:0], q_bit};
    end

    // Sign correction and divide-by-zero override applied in FIX.
    always_comb begin
        is_div    = op_reg[1];
        is_signed = ~op_reg[0];
        neg_res   = is_signed & (sa_reg ^ sb_reg);
        div0      = is_div & (b_reg == '0);
        prod_fix  = neg_res ? -acc_reg : acc_reg;
        quo_fix   = neg_res ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
        rem_fix   = sa_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
        if (div0) begin
            // Magnitude of a negated back restores the original operand.
            hi_fix = sa_reg ? -a_reg : a_reg;
            lo_fix = '1;
        end else if (is_div) begin
            hi_fix = rem_fix;
            lo_fix = quo_fix;
        end else begin
            hi_fix = prod_fix[2*WIDTH-1:WIDTH];
            lo_fix = prod_fix[WIDTH-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // Next-state logic: IDLE -> RUN on start, 32 RUN cycles, one FIX cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (cnt_reg == CW'(WIDTH-1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg  <= '0;
            op_reg   <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            sa_reg   <= 1'b0;
            sb_reg   <= 1'b0;
            acc_reg  <= '0;
            hi_reg   <= '0;
            lo_reg   <= '0;
            done_reg <= 1'b0;
            dz_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: if (bus.start) begin
                    op_reg  <= bus.op;
                    a_reg   <= in_a;
                    b_reg   <= in_b;
                    sa_reg  <= in_sa;
                    sb_reg  <= in_sb;
                    acc_reg <= '0;
                    cnt_reg <= '0;
                end
                RUN: begin
                    acc_reg <= is_div ? div_step : mul_step;
                    cnt_reg <= cnt_reg + 1'b1;
                end
                FIX: begin
                    hi_reg   <= hi_fix;
                    lo_reg   <= lo_fix;
                    dz_reg   <= div0;
                    done_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state_reg != IDLE);
    assign bus.done     = done_reg;
    assign bus.div_zero = dz_reg;
    assign bus.mul_h    = hi_reg;
    assign bus.mul_l    = lo_reg;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus randomized ops
// against a plain-arithmetic reference model.
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: MIPS semantics via 64-bit integer arithmetic.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint      x, y, q, r;
        logic [63:0] p;
        dz = 1'b0;
        p  = '0;
        case (op)
            2'd0: begin
                x = longint'($signed(a));
                y = longint'($signed(b));
                p = 64'(x * y);
            end
            2'd1: p = {32'b0, a} * {32'b0, b};
            default: begin
                if (b == 32'd0) begin
                    dz = 1'b1;
                    p  = {a, 32'hFFFF_FFFF};
                end else begin
                    if (op == 2'd2) begin
                        x = longint'($signed(a));
                        y = longint'($signed(b));
                    end else begin
                        x = longint'({32'b0, a});
                        y = longint'({32'b0, b});
                    end
                    q = x / y;
                    r = x % y;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        hi = p[63:32];
        lo = p[31:0];
    endtask

    // Issue one op (called #1 after an edge); returns #1 after the done edge.
    // poke>0 asserts a stray start at that RUN cycle, which must be ignored.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int poke);
        logic [31:0] eh, el;
        logic        edz;
        int          k, busy_cnt;
        bit          got;
        model(op, a, b, eh, el, edz);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        check("busy_after_accept", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
        busy_cnt  = bus.busy ? 1 : 0;
        got       = 1'b0;
        k         = 0;
        while (!got && k < 100) begin
            @(posedge clk); #1;
            k++;
            bus.start = (poke != 0 && k == poke);
            if (bus.done) got = 1'b1;
            else if (bus.busy) busy_cnt++;
        end
        bus.start = 1'b0;
        check("done_seen", 64'(got), 64'd1);
        check("latency", 64'(k), 64'd33);
        check("busy_cycles", 64'(busy_cnt), 64'd33);
        check("busy_at_done", 64'(bus.busy), 64'd0);
        check("mul_h", 64'(bus.mul_h), 64'(eh));
        check("mul_l", 64'(bus.mul_l), 64'(el));
        check("div_zero", 64'(bus.div_zero), 64'(edz));
        $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h dz=%0b cycles=%0d",
                 op, a, b, bus.mul_h, bus.mul_l, bus.div_zero, k);
    endtask

    initial begin
        int          dones;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state.
        #2 rst = 1'b0;
        #2;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_div_zero", 64'(bus.div_zero), 64'd0);
        check("rst_mul_h", 64'(bus.mul_h), 64'd0);
        check("rst_mul_l", 64'(bus.mul_l), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Directed cases (consecutive calls are back-to-back from the done cycle).
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 0);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(2'd3, 32'd7, 32'd2, 0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'd3, 32'd5, 32'd0, 0);
        run_op(2'd1, 32'd2, 32'd3, 0);
        run_op(2'd1, 32'd3, 32'd4, 10);

        // No second done from the ignored request.
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check("stray_start_dones", 64'(dones), 64'd0);
        check("stray_start_idle", 64'(bus.busy), 64'd0);

        run_op(2'd2, 32'hFFFF_FFF0, 32'd0, 0);

        // Reset mid-operation.
        bus.start = 1'b1;
        bus.op    = 2'd3;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_div_zero", 64'(bus.div_zero), 64'd0);
        check("midrst_mul_h", 64'(bus.mul_h), 64'd0);
        check("midrst_mul_l", 64'(bus.mul_l), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        run_op(2'd3, 32'd100, 32'd7, 0);

        // Randomized ops with edge-heavy operand mix.
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = 32'($urandom);
            endcase
            run_op(rop, ra, rb, 0);
        end

        @(posedge clk); #1;
        check("done_one_cycle", 64'(bus.done), 64'd0);
        check("final_idle", 64'(bus.busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
